// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control unit: opcodes, ALU select codes,
// sequencer states and the bundle of datapath strobes the sequencer drives.
package cpu_pkg;

    localparam logic [3:0] OP_NOR  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_STA  = 4'h2;
    localparam logic [3:0] OP_JCC  = 4'h3;
    localparam logic [3:0] OP_LDA  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] UAL_NOR  = 2'b00;
    localparam logic [1:0] UAL_ADD  = 2'b01;
    localparam logic [1:0] UAL_PASS = 2'b10;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH_INS,
        ST_DECODE,
        ST_FETCH_OP,
        ST_EXE_UAL,
        ST_STORE,
        ST_JUMP,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic       init_pc;
        logic       incr_pc;
        logic       load_pc;
        logic       load_ri;
        logic       load_r1;
        logic       load_acc;
        logic       load_carry;
        logic       clear_carry;
        logic [1:0] sel_ual;
        logic       sel_adr;
        logic       enable_mem;
        logic       rw_mem;
    } ctl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH_INS) || (s == ST_FETCH_OP) || (s == ST_STORE);
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Memory access cycle counter: counts 0..MEM_LAT-1 while enabled, done on the last count.
// clr returns it to 0; ce=0 freezes the count so a stalled access resumes where it stopped.
module mem_wait_counter #(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic clr,
    output logic done
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ce) begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == CNT_W'(MEM_LAT - 1));

endmodule

// File: rtl/control_unit_fsm.sv
// Instruction sequencer for the accumulator CPU: fetch, decode, operand access, execute.
// Moore outputs; every strobe is qualified by ce, halted reflects the state alone.
//
//   state     | meaning
//   INIT      | clear PC, one cycle
//   FETCH_INS | read instruction at PC into RI, bump PC on the last access cycle
//   DECODE    | opcode settles, choose the next phase
//   FETCH_OP  | read operand at RI address into R1
//   EXE_UAL   | ALU result into ACC (carry too for ADD)
//   STORE     | write ACC to RI address
//   JUMP      | JMP / JCC resolution; JCC always clears carry
//   HALT      | absorbing until rst
module control_unit_fsm
    import cpu_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int MEM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic [OP_W-1:0] opcode,
    input  logic            carry,
    output logic            init_PC,
    output logic            incr_PC,
    output logic            load_PC,
    output logic            load_RI,
    output logic            load_R1,
    output logic            load_ACC,
    output logic            load_carry,
    output logic            clear_carry,
    output logic [1:0]      sel_UAL,
    output logic            sel_adr,
    output logic            enable_mem,
    output logic            rw_mem,
    output logic            halted
);

    localparam logic [OP_W-1:0] OPC_NOR  = OP_W'(OP_NOR);
    localparam logic [OP_W-1:0] OPC_ADD  = OP_W'(OP_ADD);
    localparam logic [OP_W-1:0] OPC_STA  = OP_W'(OP_STA);
    localparam logic [OP_W-1:0] OPC_JCC  = OP_W'(OP_JCC);
    localparam logic [OP_W-1:0] OPC_LDA  = OP_W'(OP_LDA);
    localparam logic [OP_W-1:0] OPC_JMP  = OP_W'(OP_JMP);
    localparam logic [OP_W-1:0] OPC_HALT = OP_W'(OP_HALT);

    state_t state_q;
    state_t state_d;
    logic   mem_done;
    logic   cnt_clr;
    ctl_t   ctl_raw;
    ctl_t   ctl;

    // Counter only runs inside a memory phase and restarts on every state change.
    assign cnt_clr = (state_d != state_q) || !is_mem_state(state_q);

    mem_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_mem_wait (
        .clk  (clk),
        .rst  (rst),
        .ce   (ce),
        .clr  (cnt_clr),
        .done (mem_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:      state_d = ST_FETCH_INS;
            ST_FETCH_INS: if (mem_done) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OPC_NOR, OPC_ADD, OPC_LDA: state_d = ST_FETCH_OP;
                    OPC_STA:                   state_d = ST_STORE;
                    OPC_JCC, OPC_JMP:          state_d = ST_JUMP;
                    OPC_HALT:                  state_d = ST_HALT;
                    default:                   state_d = ST_FETCH_INS;
                endcase
            end
            ST_FETCH_OP:  if (mem_done) state_d = ST_EXE_UAL;
            ST_EXE_UAL:   state_d = ST_FETCH_INS;
            ST_STORE:     if (mem_done) state_d = ST_FETCH_INS;
            ST_JUMP:      state_d = ST_FETCH_INS;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_INIT;
        endcase
    end

    always_comb begin
        ctl_raw = '0;
        unique case (state_q)
            ST_INIT: ctl_raw.init_pc = 1'b1;
            ST_FETCH_INS: begin
                ctl_raw.enable_mem = 1'b1;
                ctl_raw.load_ri    = mem_done;
                ctl_raw.incr_pc    = mem_done;
            end
            ST_FETCH_OP: begin
                ctl_raw.enable_mem = 1'b1;
                ctl_raw.sel_adr    = 1'b1;
                ctl_raw.load_r1    = mem_done;
            end
            ST_EXE_UAL: begin
                ctl_raw.load_acc   = 1'b1;
                ctl_raw.load_carry = (opcode == OPC_ADD);
                if (opcode == OPC_ADD) begin
                    ctl_raw.sel_ual = UAL_ADD;
                end else if (opcode == OPC_LDA) begin
                    ctl_raw.sel_ual = UAL_PASS;
                end else begin
                    ctl_raw.sel_ual = UAL_NOR;
                end
            end
            ST_STORE: begin
                ctl_raw.enable_mem = 1'b1;
                ctl_raw.sel_adr    = 1'b1;
                ctl_raw.rw_mem     = 1'b1;
            end
            ST_JUMP: begin
                ctl_raw.load_pc     = (opcode == OPC_JMP) || ((opcode == OPC_JCC) && !carry);
                ctl_raw.clear_carry = (opcode == OPC_JCC);
            end
            default: ctl_raw = '0;
        endcase
    end

    assign ctl = ce ? ctl_raw : '0;

    assign init_PC     = ctl.init_pc;
    assign incr_PC     = ctl.incr_pc;
    assign load_PC     = ctl.load_pc;
    assign load_RI     = ctl.load_ri;
    assign load_R1     = ctl.load_r1;
    assign load_ACC    = ctl.load_acc;
    assign load_carry  = ctl.load_carry;
    assign clear_carry = ctl.clear_carry;
    assign sel_UAL     = ctl.sel_ual;
    assign sel_adr     = ctl.sel_adr;
    assign enable_mem  = ctl.enable_mem;
    assign rw_mem      = ctl.rw_mem;
    assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: two instances (MEM_LAT 1 and 3) share the stimulus; a queue of
// per-cycle stimulus plus expected output vectors is replayed and compared on the falling edge.
module tb_control_unit_fsm;

    // Output vector bit order:
    // {init_PC, incr_PC, load_PC, load_RI, load_R1, load_ACC, load_carry, clear_carry,
    //  sel_UAL[1:0], sel_adr, enable_mem, rw_mem, halted}
    localparam logic [13:0] M_INIT = 14'h2000;
    localparam logic [13:0] M_INCR = 14'h1000;
    localparam logic [13:0] M_LDPC = 14'h0800;
    localparam logic [13:0] M_LDRI = 14'h0400;
    localparam logic [13:0] M_LDR1 = 14'h0200;
    localparam logic [13:0] M_LACC = 14'h0100;
    localparam logic [13:0] M_LDC  = 14'h0080;
    localparam logic [13:0] M_CLRC = 14'h0040;
    localparam logic [13:0] M_SADD = 14'h0010;
    localparam logic [13:0] M_SPAS = 14'h0020;
    localparam logic [13:0] M_ADR  = 14'h0008;
    localparam logic [13:0] M_EN   = 14'h0004;
    localparam logic [13:0] M_RW   = 14'h0002;
    localparam logic [13:0] M_HALT = 14'h0001;

    typedef struct packed {
        logic        ce;
        logic [3:0]  op;
        logic        cy;
        logic [13:0] exp;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [3:0] opcode;
    logic       carry;
    wire [13:0] o1;
    wire [13:0] o3;

    ent_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    control_unit_fsm #(.OP_W(4), .MEM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .ce(ce), .opcode(opcode), .carry(carry),
        .init_PC(o1[13]), .incr_PC(o1[12]), .load_PC(o1[11]), .load_RI(o1[10]),
        .load_R1(o1[9]), .load_ACC(o1[8]), .load_carry(o1[7]), .clear_carry(o1[6]),
        .sel_UAL(o1[5:4]), .sel_adr(o1[3]), .enable_mem(o1[2]), .rw_mem(o1[1]),
        .halted(o1[0])
    );

    control_unit_fsm #(.OP_W(4), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .ce(ce), .opcode(opcode), .carry(carry),
        .init_PC(o3[13]), .incr_PC(o3[12]), .load_PC(o3[11]), .load_RI(o3[10]),
        .load_R1(o3[9]), .load_ACC(o3[8]), .load_carry(o3[7]), .clear_carry(o3[6]),
        .sel_UAL(o3[5:4]), .sel_adr(o3[3]), .enable_mem(o3[2]), .rw_mem(o3[1]),
        .halted(o3[0])
    );

    task automatic push(input logic c_e, input logic [3:0] op, input logic cy,
                        input logic [13:0] exp);
        ent_t e;
        e.ce  = c_e;
        e.op  = op;
        e.cy  = cy;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_fetch(input logic [3:0] op, input int lat);
        for (int i = 0; i < lat; i++)
            push(1'b1, op, 1'b0, (i == lat - 1) ? (M_EN | M_INCR | M_LDRI) : M_EN);
    endtask

    // Expected cycle-by-cycle strobes for one complete instruction (HALT stops after DECODE).
    task automatic push_instr(input logic [3:0] op, input logic cy, input int lat);
        push_fetch(op, lat);
        push(1'b1, op, cy, 14'h0);
        case (op)
            4'h0, 4'h1, 4'h4: begin
                for (int i = 0; i < lat; i++)
                    push(1'b1, op, cy, (i == lat - 1) ? (M_EN | M_ADR | M_LDR1) : (M_EN | M_ADR));
                if (op == 4'h1)      push(1'b1, op, cy, M_LACC | M_LDC | M_SADD);
                else if (op == 4'h4) push(1'b1, op, cy, M_LACC | M_SPAS);
                else                 push(1'b1, op, cy, M_LACC);
            end
            4'h2: for (int i = 0; i < lat; i++) push(1'b1, op, cy, M_EN | M_ADR | M_RW);
            4'h3: push(1'b1, op, cy, cy ? M_CLRC : (M_CLRC | M_LDPC));
            4'h5: push(1'b1, op, cy, M_LDPC);
            default: ;
        endcase
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ce  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Replays the queue one cycle per entry: drive at posedge+1, compare at negedge.
    task automatic drain(input int which);
        ent_t        e;
        logic [13:0] got;
        int          step;
        step = 0;
        while (sb.size() > 0) begin
            e      = sb.pop_front();
            ce     = e.ce;
            opcode = e.op;
            carry  = e.cy;
            @(negedge clk);
            got = (which == 3) ? o3 : o1;
            checks++;
            if (got !== e.exp) begin
                errors++;
                $display("FAIL seq dut%0d step %0d op=%h ce=%b actual=%h expected=%h",
                         which, step, e.op, e.ce, got, e.exp);
            end
            step++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        ce  = 1'b0;
        @(negedge clk);
        checks++;
        if (o1 !== 14'h0 || o3 !== 14'h0) begin
            errors++;
            $display("FAIL reset_ce0 actual=%h/%h expected=%h", o1, o3, 14'h0);
        end
        ce = 1'b1;
        #1;
        checks++;
        if (o1 !== M_INIT || o3 !== M_INIT) begin
            errors++;
            $display("FAIL reset_ce1 actual=%h/%h expected=%h", o1, o3, M_INIT);
        end
        @(posedge clk);
        #1;
        checks++;
        if (o1 !== M_INIT) begin
            errors++;
            $display("FAIL reset_held actual=%h expected=%h", o1, M_INIT);
        end
        rst = 1'b0;
        push(1'b1, 4'h7, 1'b0, M_INIT);
        push_fetch(4'h7, 1);
        drain(1);
        reset_dut();
        push(1'b1, 4'h7, 1'b0, M_INIT);
        push_fetch(4'h7, 3);
        drain(3);
    endtask

    task automatic test_add();
        reset_dut();
        push(1'b1, 4'h1, 1'b0, M_INIT);
        push_instr(4'h1, 1'b0, 1);
        push(1'b1, 4'h7, 1'b0, M_EN | M_INCR | M_LDRI);
        drain(1);
    endtask

    task automatic test_jcc();
        reset_dut();
        push(1'b1, 4'h3, 1'b1, M_INIT);
        push_instr(4'h3, 1'b1, 1);
        push_instr(4'h3, 1'b0, 1);
        push(1'b1, 4'h7, 1'b0, M_EN | M_INCR | M_LDRI);
        drain(1);
    endtask

    task automatic test_sta_lat3();
        reset_dut();
        push(1'b1, 4'h2, 1'b0, M_INIT);
        push_instr(4'h2, 1'b0, 3);
        push(1'b1, 4'h7, 1'b0, M_EN);
        drain(3);
    endtask

    task automatic test_ce_stall();
        reset_dut();
        push(1'b1, 4'h1, 1'b0, M_INIT);
        push_fetch(4'h1, 3);
        push(1'b1, 4'h1, 1'b0, 14'h0);
        push(1'b1, 4'h1, 1'b0, M_EN | M_ADR);
        push(1'b0, 4'h1, 1'b0, 14'h0);
        push(1'b0, 4'h1, 1'b0, 14'h0);
        push(1'b1, 4'h1, 1'b0, M_EN | M_ADR);
        push(1'b1, 4'h1, 1'b0, M_EN | M_ADR | M_LDR1);
        push(1'b1, 4'h1, 1'b0, M_LACC | M_LDC | M_SADD);
        push(1'b1, 4'h7, 1'b0, M_EN);
        drain(3);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        push(1'b1, 4'h0, 1'b0, M_INIT);
        push_instr(4'h0, 1'b0, 1);
        push_instr(4'h4, 1'b1, 1);
        push_instr(4'h7, 1'b0, 1);
        push_instr(4'h5, 1'b1, 1);
        push_instr(4'h2, 1'b0, 1);
        push_instr(4'hA, 1'b0, 1);
        push_instr(4'h1, 1'b1, 1);
        drain(1);
        reset_dut();
        push(1'b1, 4'h4, 1'b0, M_INIT);
        push_instr(4'h4, 1'b0, 3);
        push_instr(4'h0, 1'b0, 3);
        push_instr(4'h5, 1'b0, 3);
        drain(3);
    endtask

    task automatic test_halt();
        reset_dut();
        push(1'b1, 4'hF, 1'b0, M_INIT);
        push_instr(4'hF, 1'b0, 1);
        for (int i = 0; i < 6; i++) push(1'b1, (i % 2 == 0) ? 4'h1 : 4'h5, 1'b0, M_HALT);
        drain(1);
    endtask

    task automatic test_rst_mid_store();
        reset_dut();
        push(1'b1, 4'h2, 1'b0, M_INIT);
        push_fetch(4'h2, 3);
        push(1'b1, 4'h2, 1'b0, 14'h0);
        push(1'b1, 4'h2, 1'b0, M_EN | M_ADR | M_RW);
        push(1'b1, 4'h2, 1'b0, M_EN | M_ADR | M_RW);
        drain(3);
        #2;
        checks++;
        if (o3 !== (M_EN | M_ADR | M_RW)) begin
            errors++;
            $display("FAIL pre_rst_store actual=%h expected=%h", o3, M_EN | M_ADR | M_RW);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (o3 !== M_INIT) begin
            errors++;
            $display("FAIL async_rst_store actual=%h expected=%h", o3, M_INIT);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(1'b1, 4'h7, 1'b0, M_INIT);
        push_fetch(4'h7, 3);
        push(1'b1, 4'h7, 1'b0, 14'h0);
        push(1'b1, 4'h7, 1'b0, M_EN);
        drain(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        ce     = 1'b1;
        opcode = 4'h7;
        carry  = 1'b0;
        test_reset();
        test_add();
        test_jcc();
        test_sta_lat3();
        test_ce_stall();
        test_back_to_back();
        test_halt();
        test_rst_mid_store();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
